iodelay_tap_calib: RTL and testbench

Tap-sweep calibration controller for the gate-path IODELAYE1 (VARIABLE mode, 32 taps).
- Drives the delay element's RST/CE/INC controls and samples the delayed gate signal it returns.
- Sweeps taps from 0 until the sampled level changes (the edge), then parks the delay at edge + offset.
- Replaces the manual DIP-switch single-step path with an automatic search triggered by a start pulse.

---
 rtl/iodelay_tap_calib.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_iodelay_tap_calib.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iodelay_tap_calib.sv
// -----------------------------------------------------------------------------
// iodelay_tap_calib
//
// Tap-sweep calibration controller for a gate-path IODELAYE1 used in VARIABLE
// mode. After a start request the delay element is reset to tap 0. Each tap is
// then sampled for SAMPLE_CNT cycles and classified as LOW, HIGH or MIX. The
// sweep steps one tap at a time until the class differs from the tap-0
// reference (the edge). The delay element is then re-zeroed and stepped up to
// edge + EDGE_OFFSET, saturated at TAP_MAX. If no edge is found by TAP_MAX,
// fail is raised and the delay is parked at TAP_MAX/2.
//
// Ports
//   clk         in   IODELAYE1 control clock (C input of the delay element)
//   resetn      in   asynchronous active-low reset
//   start       in   one-cycle calibration request (ignored while busy)
//   delayed_in  in   delayed gate signal, asynchronous, synchronised here
//   idelay_rst  out  delay-element RST pulse (loads tap 0)
//   idelay_ce   out  delay-element CE pulse
//   idelay_inc  out  delay-element INC (always equal to idelay_ce)
//   busy        out  calibration in progress
//   done        out  one-cycle pulse at the end of calibration
//   locked      out  a final tap has been applied
//   fail        out  no edge was found during the sweep
//   tap_value   out  tap currently loaded in the delay element
//   edge_tap    out  detected edge tap
//
// Optional feature
//   IODELAY_TAP_CALIB_AUTOSTART_EN: when defined, a one-shot injects a start
//   in the first cycle after resetn deasserts. The external start still works.
// -----------------------------------------------------------------------------
module iodelay_tap_calib #(
    parameter int TAP_MAX     = 31,
    parameter int TAP_W       = 5,
    parameter int SAMPLE_CNT  = 64,
    parameter int CNT_W       = 8,
    parameter int SETTLE_CYC  = 8,
    parameter int EDGE_OFFSET = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             delayed_in,
    output logic             idelay_rst,
    output logic             idelay_ce,
    output logic             idelay_inc,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             fail,
    output logic [TAP_W-1:0] tap_value,
    output logic [TAP_W-1:0] edge_tap
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_STEP,
        S_MOVE_RST,
        S_MOVE_INC,
        S_FIN
    } state_e;

    typedef enum logic [1:0] {
        CLS_LOW,
        CLS_HIGH,
        CLS_MIX
    } cls_e;

    // Where SETTLE hands over once the delay line has settled.
    typedef enum logic {
        RET_SAMPLE,
        RET_FIN
    } ret_e;

    localparam logic [TAP_W-1:0] TAP_MAX_V   = TAP_W'(TAP_MAX);
    localparam logic [TAP_W-1:0] TAP_HALF_V  = TAP_W'(TAP_MAX / 2);
    localparam logic [TAP_W:0]   TAP_MAX_X   = (TAP_W+1)'(TAP_MAX);
    localparam logic [TAP_W:0]   OFFSET_X    = (TAP_W+1)'(EDGE_OFFSET);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CNT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_FULL = CNT_W'(SAMPLE_CNT);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    ret_e             ret_q, ret_d;
    cls_e             ref_q, ref_d;
    cls_e             cls;
    logic [CNT_W-1:0] cnt_q, cnt_d;        // shared by SETTLE and SAMPLE
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] edge_q, edge_d;
    logic             rst_q, rst_d;
    logic             ce_q, ce_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic             sync1_q, sync2_q;
    logic             start_int;
    logic [TAP_W:0]   move_sum;

`ifdef IODELAY_TAP_CALIB_AUTOSTART_EN
    // Armed by reset, fires exactly once in the first cycle after release.
    logic armed_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed_q <= 1'b1;
        end else begin
            armed_q <= 1'b0;
        end
    end

    assign start_int = start | armed_q;
`else
    assign start_int = start;
`endif

    // One bit wider than a tap so edge + offset cannot wrap before saturation.
    assign move_sum = {1'b0, edge_q} + OFFSET_X;

    always_comb begin
        if (ones_q == '0) begin
            cls = CLS_LOW;
        end else if (ones_q == SAMPLE_FULL) begin
            cls = CLS_HIGH;
        end else begin
            cls = CLS_MIX;
        end
    end

    // Control pulses are decided on the transition into the state that owns
    // them, so the registered outputs are high for exactly that state's cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave a signal unassigned and infer a latch.
        state_d  = state_q;
        ret_d    = ret_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        target_d = target_q;
        tap_d    = tap_q;
        edge_d   = edge_q;
        rst_d    = 1'b0;
        ce_d     = 1'b0;
        done_d   = 1'b0;
        locked_d = locked_q;
        fail_d   = fail_q;

        case (state_q)
            S_IDLE: begin
                if (start_int) begin
                    state_d  = S_RST;
                    rst_d    = 1'b1;
                    tap_d    = '0;
                    edge_d   = '0;
                    target_d = '0;
                    locked_d = 1'b0;
                    fail_d   = 1'b0;
                end
            end

            S_RST: begin
                state_d = S_SETTLE;
                ret_d   = RET_SAMPLE;
                cnt_d   = '0;
            end

            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d  = '0;
                    ones_d = '0;
                    if (ret_q == RET_FIN) begin
                        state_d  = S_FIN;
                        locked_d = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_SAMPLE: begin
                ones_d = ones_q + CNT_W'(sync2_q);
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_EVAL: begin
                if (tap_q == '0) begin
                    ref_d = cls;
                    if (cls == CLS_MIX) begin
                        // Tap 0 already sits on the transition.
                        edge_d  = '0;
                        state_d = S_MOVE_RST;
                        rst_d   = 1'b1;
                        tap_d   = '0;
                    end else begin
                        state_d = S_STEP;
                        ce_d    = 1'b1;
                        tap_d   = tap_q + 1'b1;
                    end
                end else if (cls != ref_q) begin
                    edge_d  = tap_q;
                    state_d = S_MOVE_RST;
                    rst_d   = 1'b1;
                    tap_d   = '0;
                end else if (tap_q == TAP_MAX_V) begin
                    // No edge anywhere: park mid-range so the path still works.
                    fail_d   = 1'b1;
                    edge_d   = '0;
                    target_d = TAP_HALF_V;
                    state_d  = S_MOVE_RST;
                    rst_d    = 1'b1;
                    tap_d    = '0;
                end else begin
                    state_d = S_STEP;
                    ce_d    = 1'b1;
                    tap_d   = tap_q + 1'b1;
                end
            end

            S_STEP: begin
                state_d = S_SETTLE;
                ret_d   = RET_SAMPLE;
                cnt_d   = '0;
            end

            S_MOVE_RST: begin
                if (!fail_q) begin
                    target_d = (move_sum > TAP_MAX_X) ? TAP_MAX_V : move_sum[TAP_W-1:0];
                end
                state_d = S_MOVE_INC;
            end

            S_MOVE_INC: begin
                // A cycle with CE high is always followed by a gap cycle.
                if (!ce_q) begin
                    if (tap_q < target_q) begin
                        ce_d  = 1'b1;
                        tap_d = tap_q + 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        ret_d   = RET_FIN;
                        cnt_d   = '0;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            ret_q    <= RET_SAMPLE;
            ref_q    <= CLS_LOW;
            cnt_q    <= '0;
            ones_q   <= '0;
            target_q <= '0;
            tap_q    <= '0;
            edge_q   <= '0;
            rst_q    <= 1'b0;
            ce_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            state_q  <= state_d;
            ret_q    <= ret_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            target_q <= target_d;
            tap_q    <= tap_d;
            edge_q   <= edge_d;
            rst_q    <= rst_d;
            ce_q     <= ce_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
            sync1_q  <= delayed_in;
            sync2_q  <= sync1_q;
        end
    end

    assign idelay_rst = rst_q;
    assign idelay_ce  = ce_q;
    assign idelay_inc = ce_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign locked     = locked_q;
    assign fail       = fail_q;
    assign tap_value  = tap_q;
    assign edge_tap   = edge_q;

endmodule

// File: tb/tb_iodelay_tap_calib.sv
module tb_iodelay_tap_calib;

    localparam int TAP_W = 5;

    typedef struct {
        string name;
        int    edge_t;
        int    tap;
        int    fl;
        int    steps;
        int    moves;
    } exp_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic             delayed_in;
    logic             idelay_rst;
    logic             idelay_ce;
    logic             idelay_inc;
    logic             busy;
    logic             done;
    logic             locked;
    logic             fail;
    logic [TAP_W-1:0] tap_value;
    logic [TAP_W-1:0] edge_tap;

    int n_vec = 0;
    int n_err = 0;

    // Delay-element model and stimulus mode.
    int   model_tap = 0;
    bit   use_tgl   = 1'b0;
    int   edge_at   = 10;
    logic tgl       = 1'b0;

    // Monitor counters.
    int rst_cnt, ce_sweep, ce_move, done_cnt, inc_bad, max_tap;

    exp_t sb[$];

    iodelay_tap_calib #(
        .TAP_MAX    (31),
        .TAP_W      (TAP_W),
        .SAMPLE_CNT (16),
        .CNT_W      (8),
        .SETTLE_CYC (4),
        .EDGE_OFFSET(8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .delayed_in(delayed_in),
        .idelay_rst(idelay_rst),
        .idelay_ce (idelay_ce),
        .idelay_inc(idelay_inc),
        .busy      (busy),
        .done      (done),
        .locked    (locked),
        .fail      (fail),
        .tap_value (tap_value),
        .edge_tap  (edge_tap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) tgl <= ~tgl;

    assign delayed_in = use_tgl ? tgl : logic'(model_tap >= edge_at);

    // IODELAYE1 tap model: RST loads 0, CE with INC steps up.
    always @(posedge clk) begin
        if (idelay_rst === 1'b1) begin
            model_tap <= 0;
        end else if (idelay_ce === 1'b1 && idelay_inc === 1'b1) begin
            model_tap <= model_tap + 1;
        end
    end

    always @(negedge clk) begin
        if (idelay_rst === 1'b1) rst_cnt++;
        if (idelay_ce === 1'b1) begin
            if (rst_cnt >= 2) ce_move++;
            else ce_sweep++;
        end
        if (done === 1'b1) done_cnt++;
        if (idelay_inc !== idelay_ce) inc_bad++;
        if (int'(tap_value) > max_tap) max_tap = int'(tap_value);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clear_counters();
        rst_cnt  = 0;
        ce_sweep = 0;
        ce_move  = 0;
        done_cnt = 0;
        inc_bad  = 0;
        max_tap  = 0;
    endtask

    function automatic exp_t mk(input string n, input int e, input int t, input int f,
                                input int s, input int m);
        exp_t r;
        r.name   = n;
        r.edge_t = e;
        r.tap    = t;
        r.fl     = f;
        r.steps  = s;
        r.moves  = m;
        return r;
    endfunction

    // Reference result for a clean LOW->HIGH transition at tap e (1..31).
    function automatic exp_t expect_edge(input string n, input int e);
        int t;
        t = (e + 8 > 31) ? 31 : e + 8;
        return mk(n, e, t, 0, e, t);
    endfunction

    function automatic logic [31:0] outs();
        return 32'({idelay_rst, idelay_ce, idelay_inc, busy, done, locked, fail,
                    tap_value, edge_tap});
    endfunction

    task automatic start_cal(input exp_t e);
        sb.push_back(e);
        clear_counters();
        start = 1'b1;
        @(posedge clk);
        #1;
        check({e.name, ".start_to_rst"}, 32'(idelay_rst), 32'd1);
        check({e.name, ".rst_tap0"}, 32'(tap_value), 32'd0);
        start = 1'b0;
    endtask

    task automatic finish_cal();
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        repeat (3) @(negedge clk);
        e = sb.pop_front();
        check({e.name, ".done_seen"}, 32'(seen), 32'd1);
        check({e.name, ".edge_tap"}, 32'(edge_tap), 32'(e.edge_t));
        check({e.name, ".tap_value"}, 32'(tap_value), 32'(e.tap));
        check({e.name, ".fail"}, 32'(fail), 32'(e.fl));
        check({e.name, ".locked"}, 32'(locked), 32'd1);
        check({e.name, ".busy_after"}, 32'(busy), 32'd0);
        check({e.name, ".step_pulses"}, 32'(ce_sweep), 32'(e.steps));
        check({e.name, ".move_pulses"}, 32'(ce_move), 32'(e.moves));
        check({e.name, ".rst_pulses"}, 32'(rst_cnt), 32'd2);
        check({e.name, ".done_pulses"}, 32'(done_cnt), 32'd1);
        check({e.name, ".inc_eq_ce"}, 32'(inc_bad), 32'd0);
        check({e.name, ".tap_le_max"}, 32'(max_tap <= 31), 32'd1);
        check({e.name, ".tap_tracks_model"}, 32'(tap_value), 32'(model_tap));
    endtask

    initial begin
        resetn = 1'b1;
        start  = 1'b0;
        clear_counters();
        #3 resetn = 1'b0;
        #1;
        check("reset_outputs", outs(), 32'd0);
        repeat (3) @(posedge clk);
        clear_counters();
`ifdef IODELAY_TAP_CALIB_AUTOSTART_EN
        sb.push_back(expect_edge("auto", 10));
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        check("autostart_rst", 32'(idelay_rst), 32'd1);
        finish_cal();
`else
        #1 resetn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("no_spontaneous_start", 32'(rst_cnt), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
`endif

        // Clean edge at tap 10.
        edge_at = 10;
        start_cal(expect_edge("edge10", 10));
        finish_cal();

        // Constant 1 at every tap: no edge, park at 15.
        edge_at = 0;
        start_cal(mk("const1", 0, 15, 1, 31, 15));
        finish_cal();

        // Toggling input makes tap 0 MIX: edge at 0, no sweep.
        use_tgl = 1'b1;
        start_cal(mk("mix0", 0, 8, 0, 0, 8));
        finish_cal();
        use_tgl = 1'b0;

        // Edge near the top: target saturates at 31.
        edge_at = 28;
        start_cal(expect_edge("edge28", 28));
        finish_cal();

        // start held through the sweep, then reset mid-SAMPLE.
        edge_at = 10;
        clear_counters();
        start = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("held_start_single_rst", 32'(rst_cnt), 32'd1);
        check("held_start_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_outputs_zero", outs(), 32'd0);
        start = 1'b0;
        @(posedge clk);
`ifdef IODELAY_TAP_CALIB_AUTOSTART_EN
        clear_counters();
        sb.push_back(expect_edge("restart", 10));
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        check("restart_auto_rst", 32'(idelay_rst), 32'd1);
        check("restart_tap0", 32'(tap_value), 32'd0);
`else
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        start_cal(expect_edge("restart", 10));
`endif
        finish_cal();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
